// File: rtl/bmp_slave_tx_if.sv
// rtl/bmp_slave_tx_if.sv - arbiter slave-port bundle between a slave transmitter and the arbiter
interface bmp_slave_tx_if #(
  parameter int DATA_BUS_SIZE = 32
) ();
  logic [1:0]               slv_mode;
  logic                     slv_data_valid;
  logic [DATA_BUS_SIZE-1:0] slv_data;
  logic [7:0]               slv_data_proc;
  logic                     slv_ready;

  modport master (
    output slv_mode,
    output slv_data_valid,
    output slv_data,
    output slv_data_proc,
    input  slv_ready
  );

  modport slave (
    input  slv_mode,
    input  slv_data_valid,
    input  slv_data,
    input  slv_data_proc,
    output slv_ready
  );
endinterface

// File: rtl/bmp_slave_tx.sv
// rtl/bmp_slave_tx.sv - buffers producer words and streams a commanded count to an arbiter slave port
module bmp_slave_tx #(
  parameter int DATA_BUS_SIZE = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int LEN_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cmd_start,
  input  logic [1:0]               i_cmd_mode,
  input  logic [7:0]               i_cmd_proc,
  input  logic [LEN_W-1:0]         i_cmd_len,
  output logic                     o_cmd_ready,
  output logic                     o_cmd_err,
  input  logic                     i_wr_en,
  input  logic [DATA_BUS_SIZE-1:0] i_wr_data,
  output logic                     o_wr_full,
  output logic                     o_wr_ovf,
  output logic                     o_tx_done,
  bmp_slave_tx_if.master           slv
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t                   r_state, w_next;
  logic [DATA_BUS_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [AW:0]              r_count;
  logic                     r_wr_ovf, r_cmd_err, r_valid;
  logic [DATA_BUS_SIZE-1:0] r_data;
  logic [1:0]               r_mode;
  logic [7:0]               r_proc;
  logic [LEN_W-1:0]         r_remaining, r_to_load;

  logic       w_full, w_empty, w_push, w_pop, w_accept, w_last, w_cmd_ok;
  logic       w_cmd_ready, w_tx_done;
  logic [1:0] w_slv_mode;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_push   = i_wr_en & ~w_full;
  assign w_accept = (r_state == S_SEND) & r_valid & slv.slv_ready;
  assign w_last   = w_accept & (r_remaining == LEN_W'(1));
  // Refill the output stage when it is empty or draining, but never beyond the commanded count.
  assign w_pop    = (r_state == S_SEND) & (~r_valid | w_accept) & ~w_empty & (r_to_load != '0);
  assign w_cmd_ok = i_cmd_start & (i_cmd_mode != 2'b00) & (i_cmd_len != '0);

  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_tx_done   = 1'b0;
    w_slv_mode  = 2'b00;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (w_cmd_ok) w_next = S_SEND;
      end
      S_SEND: begin
        w_slv_mode = r_mode;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_tx_done = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wr_ovf <= 1'b0;
    end else begin
      r_wr_ovf <= i_wr_en & w_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_err   <= 1'b0;
      r_mode      <= 2'b00;
      r_proc      <= 8'h00;
      r_remaining <= '0;
      r_to_load   <= '0;
    end else begin
      r_cmd_err <= 1'b0;
      if (r_state == S_IDLE && i_cmd_start) begin
        if (w_cmd_ok) begin
          r_mode      <= i_cmd_mode;
          r_proc      <= i_cmd_proc;
          r_remaining <= i_cmd_len;
          r_to_load   <= i_cmd_len;
        end else begin
          r_cmd_err <= 1'b1;
        end
      end else begin
        if (w_accept) r_remaining <= r_remaining - 1'b1;
        if (w_pop)    r_to_load   <= r_to_load - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_data  <= r_mem[r_rd_ptr];
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign o_cmd_ready        = w_cmd_ready;
  assign o_cmd_err          = r_cmd_err;
  assign o_wr_full          = w_full;
  assign o_wr_ovf           = r_wr_ovf;
  assign o_tx_done          = w_tx_done;
  assign slv.slv_mode       = w_slv_mode;
  assign slv.slv_data_valid = r_valid;
  assign slv.slv_data       = r_data;
  assign slv.slv_data_proc  = r_proc;

endmodule

// File: tb/tb_bmp_slave_tx.sv
// tb/tb_bmp_slave_tx.sv - directed table and sequence bench for bmp_slave_tx
module tb_bmp_slave_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [1:0]  cmd_mode = 2'b00;
  logic [7:0]  cmd_proc = 8'h00;
  logic [15:0] cmd_len = 16'h0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic        o_cmd_ready, o_cmd_err, o_wr_full, o_wr_ovf, o_tx_done;

  bmp_slave_tx_if #(.DATA_BUS_SIZE(32)) bus ();

  bmp_slave_tx #(.DATA_BUS_SIZE(32), .FIFO_DEPTH(8), .LEN_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_start (cmd_start),
    .i_cmd_mode  (cmd_mode),
    .i_cmd_proc  (cmd_proc),
    .i_cmd_len   (cmd_len),
    .o_cmd_ready (o_cmd_ready),
    .o_cmd_err   (o_cmd_err),
    .i_wr_en     (wr_en),
    .i_wr_data   (wr_data),
    .o_wr_full   (o_wr_full),
    .o_wr_ovf    (o_wr_ovf),
    .o_tx_done   (o_tx_done),
    .slv         (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic [1:0]  mode;
    logic [7:0]  proc;
    logic [15:0] len;
    logic        we;
    logic [31:0] wd;
    logic        rdy;
    logic        e_crdy;
    logic        e_err;
    logic        e_full;
    logic        e_ovf;
    logic [1:0]  e_mode;
    logic        e_val;
    logic [31:0] e_data;
    logic [7:0]  e_proc;
    logic        e_done;
  } vec_t;

  vec_t        tbl [14];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    logic was_full;
    was_full = (exp_q.size() == 8);
    wr_en    = 1'b1;
    wr_data  = w;
    step();
    wr_en    = 1'b0;
    if (!was_full) exp_q.push_back(w);
    chk("wr_ovf", {31'd0, o_wr_ovf}, {31'd0, was_full});
    chk("wr_full", {31'd0, o_wr_full}, {31'd0, exp_q.size() == 8});
  endtask

  // Bit k of pat is the ready value offered on the k-th cycle that valid is high.
  task automatic xfer(input logic [1:0] mode, input logic [7:0] proc, input logic [15:0] len,
                      input logic [15:0] pat);
    int          hs = 0;
    int          k = 0;
    int          cyc = 0;
    logic        stalled = 1'b0;
    logic        done = 1'b0;
    logic [31:0] held = 32'h0;
    logic [31:0] want;
    cmd_start = 1'b1;
    cmd_mode  = mode;
    cmd_proc  = proc;
    cmd_len   = len;
    step();
    cmd_start = 1'b0;
    chk("xfer_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
    chk("xfer_mode", {30'd0, bus.slv_mode}, {30'd0, mode});
    chk("xfer_proc", {24'd0, bus.slv_data_proc}, {24'd0, proc});
    while (!done && cyc < 60) begin
      if (o_tx_done) begin
        done = 1'b1;
      end else begin
        if (stalled) begin
          chk("hold_valid", {31'd0, bus.slv_data_valid}, 32'd1);
          chk("hold_data", bus.slv_data, held);
        end
        if (bus.slv_data_valid) begin
          chk("xfer_mode_stable", {30'd0, bus.slv_mode}, {30'd0, mode});
          chk("xfer_proc_stable", {24'd0, bus.slv_data_proc}, {24'd0, proc});
          bus.slv_ready = (k < 16) ? pat[k] : 1'b1;
          k++;
          if (bus.slv_ready) begin
            hs++;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk("xfer_data", bus.slv_data, want);
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held    = bus.slv_data;
          end
        end else begin
          bus.slv_ready = 1'b1;
        end
        step();
        cyc++;
      end
    end
    chk("xfer_done_seen", {31'd0, done}, 32'd1);
    chk("xfer_handshakes", hs, {16'd0, len});
    chk("done_valid", {31'd0, bus.slv_data_valid}, 32'd0);
    chk("done_mode", {30'd0, bus.slv_mode}, 32'd0);
    bus.slv_ready = 1'b0;
    step();
    chk("idle_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("idle_tx_done", {31'd0, o_tx_done}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"}, {30'd0, bus.slv_mode}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.slv_data_valid}, 32'd0);
    chk({tag, "_data"}, bus.slv_data, 32'd0);
    chk({tag, "_proc"}, {24'd0, bus.slv_data_proc}, 32'd0);
    chk({tag, "_cmd_ready"}, {31'd0, o_cmd_ready}, 32'd1);
    chk({tag, "_cmd_err"}, {31'd0, o_cmd_err}, 32'd0);
    chk({tag, "_full"}, {31'd0, o_wr_full}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, o_wr_ovf}, 32'd0);
    chk({tag, "_tx_done"}, {31'd0, o_tx_done}, 32'd0);
  endtask

  initial begin
    bus.slv_ready = 1'b0;

    //        cs mode   proc   len    we wd        rdy  crdy err full ovf mode  val data       proc   done
    tbl[0]  = '{0, 2'd0, 8'h00, 16'd0, 1, 32'hA0, 0,   1,   0,  0,   0,  2'd0, 0,  32'h0,     8'h00, 0};
    tbl[1]  = '{0, 2'd0, 8'h00, 16'd0, 1, 32'hA1, 0,   1,   0,  0,   0,  2'd0, 0,  32'h0,     8'h00, 0};
    tbl[2]  = '{0, 2'd0, 8'h00, 16'd0, 1, 32'hA2, 0,   1,   0,  0,   0,  2'd0, 0,  32'h0,     8'h00, 0};
    tbl[3]  = '{0, 2'd0, 8'h00, 16'd0, 1, 32'hA3, 0,   1,   0,  0,   0,  2'd0, 0,  32'h0,     8'h00, 0};
    tbl[4]  = '{1, 2'd1, 8'h5C, 16'd4, 0, 32'h0,  1,   0,   0,  0,   0,  2'd1, 0,  32'h0,     8'h5C, 0};
    tbl[5]  = '{0, 2'd0, 8'h00, 16'd0, 0, 32'h0,  1,   0,   0,  0,   0,  2'd1, 1,  32'hA0,    8'h5C, 0};
    tbl[6]  = '{0, 2'd0, 8'h00, 16'd0, 0, 32'h0,  1,   0,   0,  0,   0,  2'd1, 1,  32'hA1,    8'h5C, 0};
    tbl[7]  = '{0, 2'd0, 8'h00, 16'd0, 0, 32'h0,  1,   0,   0,  0,   0,  2'd1, 1,  32'hA2,    8'h5C, 0};
    tbl[8]  = '{0, 2'd0, 8'h00, 16'd0, 0, 32'h0,  1,   0,   0,  0,   0,  2'd1, 1,  32'hA3,    8'h5C, 0};
    tbl[9]  = '{0, 2'd0, 8'h00, 16'd0, 0, 32'h0,  1,   0,   0,  0,   0,  2'd0, 0,  32'h0,     8'h5C, 1};
    tbl[10] = '{0, 2'd0, 8'h00, 16'd0, 0, 32'h0,  0,   1,   0,  0,   0,  2'd0, 0,  32'h0,     8'h5C, 0};
    tbl[11] = '{1, 2'd0, 8'h77, 16'd5, 0, 32'h0,  0,   1,   1,  0,   0,  2'd0, 0,  32'h0,     8'h5C, 0};
    tbl[12] = '{1, 2'd2, 8'h77, 16'd0, 0, 32'h0,  0,   1,   1,  0,   0,  2'd0, 0,  32'h0,     8'h5C, 0};
    tbl[13] = '{0, 2'd0, 8'h00, 16'd0, 0, 32'h0,  0,   1,   0,  0,   0,  2'd0, 0,  32'h0,     8'h5C, 0};

    @(negedge clk);
    chk_reset_vals("in_reset");
    step();
    rst = 1'b0;
    step();
    chk_reset_vals("after_reset");

    for (int i = 0; i < 14; i++) begin
      cmd_start     = tbl[i].cs;
      cmd_mode      = tbl[i].mode;
      cmd_proc      = tbl[i].proc;
      cmd_len       = tbl[i].len;
      wr_en         = tbl[i].we;
      wr_data       = tbl[i].wd;
      bus.slv_ready = tbl[i].rdy;
      step();
      chk($sformatf("t%0d_cmd_ready", i), {31'd0, o_cmd_ready}, {31'd0, tbl[i].e_crdy});
      chk($sformatf("t%0d_cmd_err", i), {31'd0, o_cmd_err}, {31'd0, tbl[i].e_err});
      chk($sformatf("t%0d_full", i), {31'd0, o_wr_full}, {31'd0, tbl[i].e_full});
      chk($sformatf("t%0d_ovf", i), {31'd0, o_wr_ovf}, {31'd0, tbl[i].e_ovf});
      chk($sformatf("t%0d_mode", i), {30'd0, bus.slv_mode}, {30'd0, tbl[i].e_mode});
      chk($sformatf("t%0d_valid", i), {31'd0, bus.slv_data_valid}, {31'd0, tbl[i].e_val});
      if (tbl[i].e_val) chk($sformatf("t%0d_data", i), bus.slv_data, tbl[i].e_data);
      chk($sformatf("t%0d_proc", i), {24'd0, bus.slv_data_proc}, {24'd0, tbl[i].e_proc});
      chk($sformatf("t%0d_tx_done", i), {31'd0, o_tx_done}, {31'd0, tbl[i].e_done});
    end
    cmd_start = 1'b0;
    wr_en = 1'b0;
    bus.slv_ready = 1'b0;

    // Backpressure: five words buffered, three sent with stalls, two left for the next command.
    for (int i = 0; i < 5; i++) push_word(32'hB0 + i);
    xfer(2'b10, 8'h33, 16'd3, 16'hFFF9);
    chk("leftover_words", exp_q.size(), 32'd2);
    xfer(2'b01, 8'h34, 16'd2, 16'hFFFF);

    // Command first, then slow writes: each word visible one cycle after its write.
    bus.slv_ready = 1'b1;
    cmd_start = 1'b1;
    cmd_mode  = 2'b11;
    cmd_proc  = 8'h42;
    cmd_len   = 16'd2;
    step();
    cmd_start = 1'b0;
    step();
    chk("slow_idle_valid", {31'd0, bus.slv_data_valid}, 32'd0);
    for (int w = 0; w < 2; w++) begin
      push_word(32'hF0 + w);
      chk("slow_not_early", {31'd0, bus.slv_data_valid}, 32'd0);
      step();
      chk("slow_valid", {31'd0, bus.slv_data_valid}, 32'd1);
      chk("slow_data", bus.slv_data, exp_q.pop_front());
      step();
      if (w == 1) begin
        chk("slow_tx_done", {31'd0, o_tx_done}, 32'd1);
      end else begin
        chk("slow_gap_valid", {31'd0, bus.slv_data_valid}, 32'd0);
        chk("slow_gap_done", {31'd0, o_tx_done}, 32'd0);
      end
    end
    bus.slv_ready = 1'b0;
    step();
    chk("slow_idle_after", {31'd0, o_cmd_ready}, 32'd1);

    // Overflow: nine writes into an eight-deep buffer; the ninth is dropped.
    for (int i = 0; i < 9; i++) push_word(32'hC0 + i);
    step();
    chk("ovf_pulse_ends", {31'd0, o_wr_ovf}, 32'd0);
    xfer(2'b01, 8'h99, 16'd8, 16'hFFFF);
    chk("ovf_drained_full", {31'd0, o_wr_full}, 32'd0);

    // Reset asserted after two of five words are accepted.
    for (int i = 0; i < 5; i++) push_word(32'hD0 + i);
    cmd_start = 1'b1;
    cmd_mode  = 2'b11;
    cmd_proc  = 8'hAA;
    cmd_len   = 16'd5;
    step();
    cmd_start = 1'b0;
    bus.slv_ready = 1'b1;
    step();
    chk("rst_seq_d0", bus.slv_data, 32'hD0);
    step();
    chk("rst_seq_d1", bus.slv_data, 32'hD1);
    step();
    chk("rst_seq_d2", bus.slv_data, 32'hD2);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    bus.slv_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_done", {31'd0, o_tx_done}, 32'd0);
      chk("post_rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
    end
    push_word(32'hE0);
    push_word(32'hE1);
    xfer(2'b01, 8'h11, 16'd2, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule

// File: doc/bmp_slave_tx.md
Name: bmp_slave_tx

Overview:
- Slave-side transmitter that feeds the arbiter's slave port: slvN_mode, slvN_data_valid, slvN_data, slvN_data_proc out; slvN_ready in.
- A local producer pushes image words into an internal buffer and issues a transfer command (mode, processing byte, word count).
- The block presents the request to the arbiter and streams exactly the commanded number of words with a valid/ready handshake.
- One instance sits in front of each arbiter slave port.

Parameters:
- DATA_BUS_SIZE, 32, width of data words.
- FIFO_DEPTH, 8, internal buffer depth in words; power of 2, at least 2.
- LEN_W, 16, width of the transfer word count.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_start  in  1  transfer request, sampled when cmd_ready=1.
- cmd_mode  in  2  operation mode; 2'b00 is illegal.
- cmd_proc  in  8  processing parameter forwarded to the arbiter.
- cmd_len  in  LEN_W  number of words in the transfer; 0 is illegal.
- cmd_ready  out  1  high in IDLE only.
- cmd_err  out  1  one-cycle pulse when an illegal command is rejected.
- wr_en  in  1  push wr_data into the buffer.
- wr_data  in  DATA_BUS_SIZE  word to buffer.
- wr_full  out  1  buffer holds FIFO_DEPTH words.
- wr_ovf  out  1  one-cycle pulse when a write is dropped.
- slv_mode  out  2  mode presented to the arbiter; 2'b00 when not transferring.
- slv_data_valid  out  1  slv_data holds a valid word.
- slv_data  out  DATA_BUS_SIZE  word to the arbiter.
- slv_data_proc  out  8  latched cmd_proc.
- slv_ready  in  1  arbiter accepts the word when valid and ready are both high.
- tx_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async assert, sync release) values:
  - FSM=IDLE, buffer empty, counters 0.
  - slv_mode=0, slv_data_valid=0, slv_data=0, slv_data_proc=0.
  - cmd_ready=1, cmd_err=0, wr_full=0, wr_ovf=0, tx_done=0.
- Reset mid-transfer discards the buffer and the transfer. No tx_done is issued.
- Buffer:
  - Synchronous FIFO, circular pointers wrapping at FIFO_DEPTH, occupancy counter.
  - Writes are accepted in any state, so prefill during IDLE is allowed.
  - A write while wr_full=1 is dropped and pulses wr_ovf, even if a pop happens in the same cycle.
  - A simultaneous push and pop when not full leaves occupancy unchanged.
- FSM states: IDLE, SEND, DONE.
  - IDLE:
    - cmd_start with cmd_mode!=0 and cmd_len!=0: latch mode/proc/len into regs, load remaining=len and to_load=len, go to SEND next cycle.
    - Otherwise (illegal command): pulse cmd_err, stay in IDLE.
  - SEND:
    - slv_mode=latched mode, slv_data_proc=latched proc, both stable for the whole transfer. cmd_ready=0 and cmd_start is ignored.
    - Registered output stage (slv_data/slv_data_valid):
      - Loads the FIFO head when the stage is empty, or when it is being accepted this cycle, provided the FIFO is non-empty and to_load>0.
      - Each load pops the FIFO and decrements to_load.
    - Latency: a word written at edge N into an empty FIFO appears on slv_data after edge N+1.
    - Holding rule: while slv_data_valid=1 and slv_ready=0, slv_data and slv_data_valid are held unchanged.
    - Throughput: back-to-back one word per cycle when the FIFO is non-empty and slv_ready=1.
    - Each accepted word decrements remaining. Words beyond cmd_len stay in the FIFO for the next transfer.
    - When the accepted word has remaining==1: slv_data_valid clears next cycle, go to DONE.
    - slv_ready while slv_data_valid=0 has no effect.
  - DONE: tx_done=1 for this one cycle, slv_mode=0, then IDLE (cmd_ready=1 next cycle).
- Width rules:
  - Counters are LEN_W bits wide; no wrap because len!=0 is checked.
  - The FIFO occupancy counter is clog2(FIFO_DEPTH)+1 bits wide.

Test Plan:
- Prefill 4 words (0xA0..0xA3), cmd_start mode=2'b01 proc=0x5C len=4, slv_ready=1 → slv_mode=01 and slv_data_proc=0x5C through the transfer; words A0..A3 on 4 consecutive cycles; tx_done 1 cycle later; slv_mode returns to 0.
- len=3, slv_ready toggles 1,0,0,1,1 → each word is held stable while ready=0; exactly 3 handshakes; no 4th valid even though the FIFO holds 5 words; 2 words remain.
- Command issued with the FIFO empty, words written one every 3 cycles → valid rises 1 cycle after each write; tx_done after the 2nd accept for len=2.
- Write 9 words with FIFO_DEPTH=8 in IDLE → wr_full=1 after 8; 9th write pulses wr_ovf; contents are the first 8 words in order.
- cmd_mode=0 or cmd_len=0 → cmd_err pulse, FSM stays IDLE, slv_mode=0.
- Assert rst after 2 of 5 words are accepted → all outputs go to reset values immediately; no tx_done; the next command starts cleanly.
